// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: streams 64-bit words from the ITCM into the
// instruction FIFO, with a one-entry skid buffer, redirect and region-fault handling.
module fetch_sequencer #(
  parameter int          AW       = 14,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          itcm_en,
  output logic [AW-1:0] itcm_addr,
  input  logic [63:0]   itcm_rdata,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_pc,
  input  logic          fifo_full,
  output logic          fifo_push,
  output logic [63:0]   fifo_data,
  output logic [63:0]   fifo_pc,
  output logic          fetch_fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  localparam logic [63:0] PC_MASK = ~64'h7;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [63:0] issue_pc_q, issue_pc_d;
  logic [63:0] skid_data_q, skid_data_d;
  logic [63:0] skid_pc_q, skid_pc_d;
  logic        in_range;

  assign in_range  = (pc_q[63:AW+3] == RESET_PC[63:AW+3]);
  assign itcm_addr = pc_q[AW+2:3];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inflight_d  = inflight_q;
    issue_pc_d  = issue_pc_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    itcm_en     = 1'b0;
    fifo_push   = 1'b0;
    fifo_data   = 64'd0;
    fifo_pc     = 64'd0;
    fetch_fault = (state_q == FAULT) && !redirect_valid;

    if (redirect_valid) begin
      // Redirect wins everywhere: returning and skidded words are dropped.
      pc_d       = redirect_pc & PC_MASK;
      inflight_d = 1'b0;
      state_d    = FETCH;
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;

        FETCH: begin
          if (inflight_q) begin
            if (!fifo_full) begin
              fifo_push = 1'b1;
              fifo_data = itcm_rdata;
              fifo_pc   = issue_pc_q;
            end else begin
              skid_data_d = itcm_rdata;
              skid_pc_d   = issue_pc_q;
              state_d     = HOLD;
            end
          end
          inflight_d = !fifo_full && in_range;
          if (!fifo_full && in_range) begin
            itcm_en    = 1'b1;
            issue_pc_d = pc_q;
            pc_d       = (pc_q + 64'd8) & PC_MASK;
          end else if (!fifo_full && !in_range && !inflight_q) begin
            state_d = FAULT;
          end
        end

        HOLD: begin
          fifo_data = skid_data_q;
          fifo_pc   = skid_pc_q;
          if (!fifo_full) begin
            fifo_push = 1'b1;
            state_d   = FETCH;
          end else begin
            fifo_data = 64'd0;
            fifo_pc   = 64'd0;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC & PC_MASK;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  // Data-only holding registers; their validity is tracked by inflight_q / HOLD.
  always_ff @(posedge CLK) begin
    issue_pc_q  <= issue_pc_d;
    skid_data_q <= skid_data_d;
    skid_pc_q   <= skid_pc_d;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, backpressure, redirect,
// region-end fault, out-of-range redirect and reset while holding.
module tb_fetch_sequencer;

  localparam int          AW   = 14;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] TAG  = 64'hD00D_0000_0000_0000;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          itcm_en;
  logic [AW-1:0] itcm_addr;
  logic [63:0]   itcm_rdata = 64'd0;
  logic          redirect_valid = 1'b0;
  logic [63:0]   redirect_pc = 64'd0;
  logic          fifo_full = 1'b0;
  logic          fifo_push;
  logic [63:0]   fifo_data;
  logic [63:0]   fifo_pc;
  logic          fetch_fault;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  fetch_sequencer #(.AW(AW), .RESET_PC(BASE)) dut (
    .CLK(CLK), .RST(RST),
    .itcm_en(itcm_en), .itcm_addr(itcm_addr), .itcm_rdata(itcm_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fifo_full(fifo_full), .fifo_push(fifo_push),
    .fifo_data(fifo_data), .fifo_pc(fifo_pc), .fetch_fault(fetch_fault)
  );

  always #5 CLK = ~CLK;

  // ITCM model: word content is a tag ORed with its word address, one-cycle latency.
  always @(posedge CLK) if (itcm_en) itcm_rdata <= TAG | 64'(itcm_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, "_en"},    64'(itcm_en),     64'd0);
    check({tag, "_push"},  64'(fifo_push),   64'd0);
    check({tag, "_data"},  fifo_data,        64'd0);
    check({tag, "_pc"},    fifo_pc,          64'd0);
    check({tag, "_fault"}, 64'(fetch_fault), 64'd0);
  endtask

  initial begin
    // Reset state
    #1;
    idle_outputs("rst");
    tick();
    tick();
    RST = 1'b0;
    #1;
    check("idle_en", 64'(itcm_en), 64'd0);

    // Streaming
    tick();
    check("s1_en",   64'(itcm_en),   64'd1);
    check("s1_addr", 64'(itcm_addr), 64'd0);
    check("s1_push", 64'(fifo_push), 64'd0);
    for (int n = 2; n <= 6; n++) begin
      tick();
      check("s_push", 64'(fifo_push), 64'd1);
      check("s_pc",   fifo_pc,        BASE + 64'(8 * (n - 2)));
      check("s_data", fifo_data,      TAG | 64'(n - 2));
      check("s_addr", 64'(itcm_addr), 64'(n - 1));
    end

    // Backpressure: word 4 returns into a full FIFO
    fifo_full = 1'b1;
    #1;
    check("bp_push0", 64'(fifo_push), 64'd0);
    check("bp_en0",   64'(itcm_en),   64'd0);
    tick();
    check("hold_push", 64'(fifo_push), 64'd0);
    check("hold_en",   64'(itcm_en),   64'd0);
    tick();
    check("hold2_en",  64'(itcm_en),   64'd0);
    fifo_full = 1'b0;
    #1;
    check("skid_push", 64'(fifo_push), 64'd1);
    check("skid_pc",   fifo_pc,        BASE + 64'h20);
    check("skid_data", fifo_data,      TAG | 64'd4);
    check("skid_en",   64'(itcm_en),   64'd0);
    tick();
    check("res_en",   64'(itcm_en),   64'd1);
    check("res_addr", 64'(itcm_addr), 64'd5);
    check("res_push", 64'(fifo_push), 64'd0);
    tick();
    check("res_push2", 64'(fifo_push), 64'd1);
    check("res_pc2",   fifo_pc,        BASE + 64'h28);

    // Redirect while a word is inflight
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0105;
    #1;
    check("rd_push", 64'(fifo_push), 64'd0);
    check("rd_en",   64'(itcm_en),   64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("rd_en1",   64'(itcm_en),   64'd1);
    check("rd_addr1", 64'(itcm_addr), 64'h20);
    check("rd_push1", 64'(fifo_push), 64'd0);
    tick();
    check("rd_push2", 64'(fifo_push), 64'd1);
    check("rd_pc2",   fifo_pc,        64'h8000_0100);
    check("rd_data2", fifo_data,      TAG | 64'h20);

    // Region end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8001_FFF8;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("re_en",   64'(itcm_en),   64'd1);
    check("re_addr", 64'(itcm_addr), 64'h3FFF);
    tick();
    check("re_push", 64'(fifo_push), 64'd1);
    check("re_pc",   fifo_pc,        64'h8001_FFF8);
    check("re_en2",  64'(itcm_en),   64'd0);
    tick();
    check("re_en3",   64'(itcm_en),   64'd0);
    check("re_push3", 64'(fifo_push), 64'd0);
    tick();
    check("re_fault", 64'(fetch_fault), 64'd1);
    check("re_en4",   64'(itcm_en),     64'd0);
    fifo_full = 1'b1;
    tick();
    check("re_fault2", 64'(fetch_fault), 64'd1);
    check("re_push5",  64'(fifo_push),   64'd0);
    fifo_full      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = BASE;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("re_clr",    64'(fetch_fault), 64'd0);
    check("re_clr_en", 64'(itcm_en),     64'd1);
    check("re_clr_ad", 64'(itcm_addr),   64'd0);

    // Out-of-range redirect
    redirect_valid = 1'b1;
    redirect_pc    = 64'd0;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("oor_en",    64'(itcm_en),     64'd0);
    check("oor_push",  64'(fifo_push),   64'd0);
    tick();
    check("oor_fault", 64'(fetch_fault), 64'd1);
    check("oor_en2",   64'(itcm_en),     64'd0);

    // Reset while holding a skid word
    redirect_valid = 1'b1;
    redirect_pc    = BASE;
    tick();
    redirect_valid = 1'b0;
    tick();
    fifo_full = 1'b1;
    tick();
    check("rh_push", 64'(fifo_push), 64'd0);
    RST = 1'b1;
    #1;
    idle_outputs("rh_rst");
    fifo_full = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    check("rh_en", 64'(itcm_en), 64'd1);
    tick();
    check("rh_push2", 64'(fifo_push), 64'd1);
    check("rh_pc2",   fifo_pc,        BASE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
